dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 15 +
 rtl/flopr.sv | 16 +
 rtl/starve_counter.sv | 30 +++
 rtl/dmem_arbiter.sv | 124 ++++++++++++
 tb/tb_dmem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter between the CPU
// memory stage and an external request port.
package dmem_arb_pkg;

   typedef enum logic {
      NORMAL = 1'b0,
      FORCE  = 1'b1
   } arb_state_e;

   localparam int STARVE_LIMIT_DEFAULT = 4;

   localparam int               CNT_W   = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/flopr.sv
// Resettable register; clears synchronously to zero while reset is high.
module flopr #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset) q <= '0;
      else       q <= d;
   end

endmodule

// File: rtl/starve_counter.sv
// Saturating wait counter: counts blocked external-request cycles, clear wins
// over increment.
module starve_counter
   import dmem_arb_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && (cnt_q != CNT_MAX))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU has priority, an external port that waits too long
// gets a one-cycle forced slot during which the CPU is stalled.
//
//   state  | meaning
//   NORMAL | CPU access wins, external port served when the CPU is idle
//   FORCE  | one-cycle slot reserved for the external port, CPU stalled
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int WORD_WIDTH   = 32,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  MemWriteM,
   input  logic                  MemReadM,
   input  logic [WORD_WIDTH-1:0] ALUResultM,
   input  logic [WORD_WIDTH-1:0] WriteDataM,
   output logic [WORD_WIDTH-1:0] ReadDataM,
   output logic                  StallM,
   input  logic                  ext_req_valid,
   input  logic                  ext_we,
   input  logic [WORD_WIDTH-1:0] ext_addr,
   input  logic [WORD_WIDTH-1:0] ext_wdata,
   output logic                  ext_req_ready,
   output logic                  ext_rsp_valid,
   output logic [WORD_WIDTH-1:0] ext_rdata,
   output logic                  mem_we,
   output logic [WORD_WIDTH-1:0] mem_a,
   output logic [WORD_WIDTH-1:0] mem_wd,
   input  logic [WORD_WIDTH-1:0] mem_rd
);

   localparam logic [CNT_W-1:0] FORCE_AT = CNT_W'(STARVE_LIMIT - 1);

   arb_state_e             state_d, state_q;
   logic                   cpu_access;
   logic                   gnt_cpu, gnt_ext, stall;
   logic                   ext_hs, ext_blocked;
   logic [CNT_W-1:0]       wait_cnt;
   logic                   rsp_valid_d, rsp_valid_q;
   logic [WORD_WIDTH-1:0]  rdata_d, rdata_q;

   assign cpu_access = MemReadM | MemWriteM;

   always_comb begin
      gnt_cpu = 1'b0;
      gnt_ext = 1'b0;
      stall   = 1'b0;
      case (state_q)
         NORMAL: begin
            gnt_cpu = cpu_access;
            gnt_ext = !cpu_access && ext_req_valid;
         end
         FORCE: begin
            // A dropped external request leaves the slot idle and the CPU unstalled.
            gnt_ext = ext_req_valid;
            stall   = cpu_access && ext_req_valid;
         end
         default: ;
      endcase
   end

   assign ext_hs      = ext_req_valid & gnt_ext;
   assign ext_blocked = ext_req_valid & !gnt_ext;

   always_comb begin
      state_d = NORMAL;
      if ((state_q == NORMAL) && ext_blocked && (wait_cnt == FORCE_AT))
         state_d = FORCE;
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= NORMAL;
      else       state_q <= state_d;
   end

   starve_counter u_starve_counter (
      .clk   (clk),
      .reset (reset),
      .clr   (ext_hs | !ext_req_valid),
      .inc   (ext_blocked),
      .cnt   (wait_cnt)
   );

   always_comb begin
      mem_we = 1'b0;
      if (gnt_cpu)      mem_we = MemWriteM;
      else if (gnt_ext) mem_we = ext_we;
   end

   assign mem_a  = gnt_ext ? ext_addr  : ALUResultM;
   assign mem_wd = gnt_ext ? ext_wdata : WriteDataM;

   assign ReadDataM     = mem_rd;
   assign StallM        = stall;
   assign ext_req_ready = gnt_ext;

   // Writes answer with zero data; reads capture the array output at the handshake.
   always_comb begin
      rsp_valid_d = ext_hs;
      rdata_d     = rdata_q;
      if (ext_hs)
         rdata_d = ext_we ? '0 : mem_rd;
   end

   flopr #(.WIDTH(1)) u_rsp_valid_reg (
      .clk   (clk),
      .reset (reset),
      .d     (rsp_valid_d),
      .q     (rsp_valid_q)
   );

   flopr #(.WIDTH(WORD_WIDTH)) u_rdata_reg (
      .clk   (clk),
      .reset (reset),
      .d     (rdata_d),
      .q     (rdata_q)
   );

   assign ext_rsp_valid = rsp_valid_q;
   assign ext_rdata     = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic, all
// checked against a cycle-level reference of the arbitration rules.
module tb_dmem_arbiter;

   localparam int W   = 32;
   localparam int LIM = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         MemWriteM, MemReadM;
   logic [W-1:0] ALUResultM, WriteDataM, ReadDataM;
   logic         StallM;
   logic         ext_req_valid, ext_we;
   logic [W-1:0] ext_addr, ext_wdata;
   logic         ext_req_ready, ext_rsp_valid;
   logic [W-1:0] ext_rdata;
   logic         mem_we;
   logic [W-1:0] mem_a, mem_wd, mem_rd;

   always #5 clk = ~clk;

   dmem_arbiter #(.WORD_WIDTH(W), .STARVE_LIMIT(LIM)) dut (
      .clk           (clk),
      .reset         (reset),
      .MemWriteM     (MemWriteM),
      .MemReadM      (MemReadM),
      .ALUResultM    (ALUResultM),
      .WriteDataM    (WriteDataM),
      .ReadDataM     (ReadDataM),
      .StallM        (StallM),
      .ext_req_valid (ext_req_valid),
      .ext_we        (ext_we),
      .ext_addr      (ext_addr),
      .ext_wdata     (ext_wdata),
      .ext_req_ready (ext_req_ready),
      .ext_rsp_valid (ext_rsp_valid),
      .ext_rdata     (ext_rdata),
      .mem_we        (mem_we),
      .mem_a         (mem_a),
      .mem_wd        (mem_wd),
      .mem_rd        (mem_rd)
   );

   // Data memory seen by the DUT: 64 words, combinational read.
   logic [W-1:0] ram [64] = '{default: '0};
   assign mem_rd = ram[mem_a[7:2]];
   always @(posedge clk) if (mem_we) ram[mem_a[7:2]] <= mem_wd;

   // Reference state: forced-slot flag, blocked-cycle count, response, memory image.
   bit           m_force;
   int           m_wait;
   logic         m_rv;
   logic [W-1:0] m_rd;
   logic [W-1:0] shadow [64] = '{default: '0};

   bit           p_gcpu, p_gext, p_stall;
   logic         e_we;
   logic [W-1:0] e_a, e_wd;
   bit           l_stall, l_hs;

   logic         s_ready, s_stall, s_we, s_rv;
   logic [W-1:0] s_a, s_rdata;

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void predict();
      bit cpu;
      cpu = MemReadM | MemWriteM;
      if (m_force) begin
         p_gcpu  = 1'b0;
         p_gext  = ext_req_valid;
         p_stall = cpu & ext_req_valid;
      end else begin
         p_gcpu  = cpu;
         p_gext  = !cpu & ext_req_valid;
         p_stall = 1'b0;
      end
      e_we = p_gcpu ? MemWriteM : (p_gext ? ext_we : 1'b0);
      e_a  = p_gext ? ext_addr  : ALUResultM;
      e_wd = p_gext ? ext_wdata : WriteDataM;
   endfunction

   function automatic void model_update();
      bit           blk, nf;
      logic [W-1:0] rd_now;
      predict();
      rd_now = shadow[ext_addr[7:2]];
      if (p_gcpu && MemWriteM) shadow[ALUResultM[7:2]] = WriteDataM;
      if (p_gext && ext_we)    shadow[ext_addr[7:2]]   = ext_wdata;
      if (reset) begin
         m_force = 1'b0;
         m_wait  = 0;
         m_rv    = 1'b0;
         m_rd    = '0;
      end else begin
         m_rv = p_gext;
         if (p_gext) m_rd = ext_we ? '0 : rd_now;
         blk     = ext_req_valid && !p_gext;
         nf      = !m_force && blk && (m_wait + 1 >= LIM);
         m_wait  = blk ? ((m_wait + 1 > 15) ? 15 : m_wait + 1) : 0;
         m_force = nf;
      end
      l_stall = p_stall;
      l_hs    = p_gext;
   endfunction

   task automatic tick();
      @(negedge clk);
      predict();
      s_ready = ext_req_ready;
      s_stall = StallM;
      s_we    = mem_we;
      s_a     = mem_a;
      s_rv    = ext_rsp_valid;
      s_rdata = ext_rdata;
      chk("ready",     W'(ext_req_ready), W'(p_gext));
      chk("stall",     W'(StallM),        W'(p_stall));
      chk("mem_we",    W'(mem_we),        W'(e_we));
      chk("mem_a",     mem_a,             e_a);
      chk("mem_wd",    mem_wd,            e_wd);
      chk("cpu_rdata", ReadDataM,         shadow[e_a[7:2]]);
      chk("rsp_valid", W'(ext_rsp_valid), W'(m_rv));
      chk("rsp_data",  ext_rdata,         m_rd);
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic set_cpu(input bit rd, input bit wr, input logic [W-1:0] a, input logic [W-1:0] d);
      MemReadM = rd; MemWriteM = wr; ALUResultM = a; WriteDataM = d;
   endtask

   task automatic set_ext(input bit v, input bit we, input logic [W-1:0] a, input logic [W-1:0] d);
      ext_req_valid = v; ext_we = we; ext_addr = a; ext_wdata = d;
   endtask

   initial begin
      reset = 1'b1;
      set_cpu(0, 0, '0, '0);
      set_ext(0, 0, '0, '0);
      repeat (2) @(posedge clk);
      #1;
      m_force = 1'b0; m_wait = 0; m_rv = 1'b0; m_rd = '0;
      reset = 1'b0;

      // reset state
      tick();
      chk("rst_rv",    W'(s_rv),    '0);
      chk("rst_rdata", s_rdata,     '0);
      chk("rst_stall", W'(s_stall), '0);

      // external write then read of 0x40 with idle CPU
      set_ext(1, 1, 32'h40, 32'hDEAD_BEEF);
      tick();
      set_ext(1, 0, 32'h40, '0);
      tick();
      chk("rd40_ready", W'(s_ready), 32'd1);
      set_ext(0, 0, '0, '0);
      tick();
      chk("rd40_rv",   W'(s_rv), 32'd1);
      chk("rd40_data", s_rdata,  32'hDEAD_BEEF);

      // starvation: CPU loads every cycle while an external write waits
      tick();
      set_cpu(1, 0, 32'h10, '0);
      set_ext(1, 1, 32'h20, 32'h5555_AAAA);
      for (int i = 0; i < LIM; i++) begin
         tick();
         chk("starve_ready", W'(s_ready), '0);
         chk("starve_stall", W'(s_stall), '0);
      end
      tick();
      chk("force_stall", W'(s_stall), 32'd1);
      chk("force_ready", W'(s_ready), 32'd1);
      chk("force_we",    W'(s_we),    32'd1);
      set_ext(0, 0, '0, '0);
      tick();
      chk("after_stall", W'(s_stall), '0);
      chk("after_a",     s_a,         32'h10);
      chk("after_rv",    W'(s_rv),    32'd1);
      chk("after_data",  s_rdata,     '0);
      chk("force_ram",   ram[8],      32'h5555_AAAA);

      // colliding stores to 0x8: CPU first, external next
      set_cpu(0, 1, 32'h8, 32'h11);
      set_ext(1, 1, 32'h8, 32'h22);
      tick();
      chk("coll_cpu", ram[2], 32'h11);
      set_cpu(0, 0, '0, '0);
      tick();
      chk("coll_ext", ram[2], 32'h22);
      set_ext(0, 0, '0, '0);
      tick();

      // reset the cycle after a read handshake drops everything
      set_ext(1, 0, 32'h40, '0);
      tick();
      set_ext(0, 0, '0, '0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      chk("rst_hs_rv", W'(s_rv), '0);
      tick();
      chk("rst_hs_rv2", W'(s_rv), '0);

      // handshake while reset is high gives no pulse
      set_ext(1, 0, 32'h40, '0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      set_ext(0, 0, '0, '0);
      tick();
      chk("rst_same_rv", W'(s_rv), '0);

      // reset clears partial starvation count
      set_cpu(1, 0, 32'h14, '0);
      set_ext(1, 0, 32'h24, '0);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < LIM; i++) begin
         tick();
         chk("rst_cnt_ready", W'(s_ready), '0);
      end
      tick();
      chk("rst_cnt_force", W'(s_ready), 32'd1);
      set_cpu(0, 0, '0, '0);
      set_ext(0, 0, '0, '0);
      tick();

      // back-to-back reads of 0x0 and 0x4
      set_ext(1, 1, 32'h0, 32'hA0A0_A0A0);
      tick();
      set_ext(1, 1, 32'h4, 32'hB1B1_B1B1);
      tick();
      set_ext(1, 0, 32'h0, '0);
      tick();
      set_ext(1, 0, 32'h4, '0);
      tick();
      chk("b2b_rv0",   W'(s_rv), 32'd1);
      chk("b2b_data0", s_rdata,  32'hA0A0_A0A0);
      set_ext(0, 0, '0, '0);
      tick();
      chk("b2b_rv1",   W'(s_rv), 32'd1);
      chk("b2b_data1", s_rdata,  32'hB1B1_B1B1);
      tick();
      chk("b2b_rv2",   W'(s_rv), '0);

      // random traffic; requesters hold while stalled / not yet accepted
      for (int n = 0; n < 800; n++) begin
         int r;
         reset = ($urandom_range(0, 59) == 0);
         if (!l_stall) begin
            r = $urandom_range(0, 3);
            set_cpu(r == 1, r == 2, W'({$urandom_range(0, 63), 2'b00}), $urandom);
         end
         if (!(ext_req_valid && !l_hs)) begin
            set_ext($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                    W'({$urandom_range(0, 63), 2'b00}), $urandom);
         end
         tick();
      end
      reset = 1'b0;

      for (int i = 0; i < 64; i++)
         chk("final_ram", ram[i], shadow[i]);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
